// File: rtl/bmf_block_renorm.sv
// Block renormaliser that sits behind fp_mul: buffers one block of products, finds the largest
// exponent overflow S, then replays the block with every exponent lowered by S.
module bmf_block_renorm #(
    parameter int NEXP       = 4,
    parameter int NSIG       = 3,
    parameter int BLOCK_SIZE = 8,
    parameter int LAST_FLAG  = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NEXP+NSIG:0]   in_p,
    input  logic [NEXP:0]        in_ovf,
    input  logic [LAST_FLAG-1:0] in_flags,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NEXP+NSIG:0]   out_p,
    output logic [LAST_FLAG-1:0] out_flags,
    output logic                 out_last,
    output logic [NEXP:0]        block_shift
);

    localparam int PW = NEXP + NSIG + 1;
    localparam int EW = NEXP + 3;
    localparam int CW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

    // Flag bit positions shared with fp_mul.
    localparam int SNAN      = 0;
    localparam int QNAN      = 1;
    localparam int INFINITY  = 2;
    localparam int ZERO      = 3;
    localparam int SUBNORMAL = 4;
    localparam int NORMAL    = 5;

    localparam logic [0:0] FILL  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    localparam logic [CW-1:0]        LAST_IDX = CW'(BLOCK_SIZE - 1);
    localparam logic signed [EW-1:0] EXP_TOP  = EW'((1 << NEXP) - 2);

    typedef struct packed {
        logic [PW-1:0]        p;
        logic [LAST_FLAG-1:0] flags;
    } renorm_t;

    function automatic renorm_t renorm(input logic [PW-1:0]        p,
                                       input logic [NEXP:0]        ovf,
                                       input logic [LAST_FLAG-1:0] flags,
                                       input logic [NEXP:0]        shift);
        renorm_t                r;
        logic                   sign;
        logic [NSIG:0]          mant;
        logic [NSIG:0]          shifted;
        logic signed [EW-1:0]   expExt;
        logic signed [EW-1:0]   expNew;
        logic signed [EW-1:0]   k;
        sign    = p[PW-1];
        mant    = {1'b1, p[NSIG-1:0]};
        expExt  = signed'({3'b000, p[PW-2:NSIG]});
        r.p     = '0;
        r.flags = '0;
        if (flags[INFINITY]) begin
            expExt = EXP_TOP + signed'({2'b00, ovf});
        end else if (flags[SUBNORMAL]) begin
            expExt = EW'(1);
            mant   = {1'b0, p[NSIG-1:0]};
        end
        expNew  = expExt - signed'({2'b00, shift});
        k       = EW'(1) - expNew;
        shifted = mant >> k;
        if (flags[ZERO]) begin
            r.p           = p;
            r.flags[ZERO] = 1'b1;
        end else if (expNew > 0) begin
            r.p             = {sign, expNew[NEXP-1:0], mant[NSIG-1:0]};
            r.flags[NORMAL] = 1'b1;
        end else if (k > NSIG || shifted == '0) begin
            // Underflow saturates to the smallest subnormal, tagged ZERO, as fp_mul does.
            r.p           = {sign, {(PW-2){1'b0}}, 1'b1};
            r.flags[ZERO] = 1'b1;
        end else begin
            r.p                = {sign, {NEXP{1'b0}}, shifted[NSIG-1:0]};
            r.flags[SUBNORMAL] = 1'b1;
        end
        return r;
    endfunction

    logic [0:0]           state;
    logic [CW-1:0]        wrCnt;
    logic [CW-1:0]        rdCnt;
    logic [CW-1:0]        rdNext;
    logic [NEXP:0]        shiftAcc;
    logic [NEXP:0]        curOvf;
    logic [NEXP:0]        shiftNext;
    logic [PW-1:0]        entP     [BLOCK_SIZE];
    logic [NEXP:0]        entOvf   [BLOCK_SIZE];
    logic [LAST_FLAG-1:0] entFlags [BLOCK_SIZE];
    renorm_t              firstRes;
    renorm_t              nextRes;

    assign in_ready  = (state == FILL);
    assign out_valid = (state == DRAIN);

    assign curOvf    = in_flags[INFINITY] ? in_ovf : '0;
    assign shiftNext = (curOvf > shiftAcc) ? curOvf : shiftAcc;
    assign rdNext    = (rdCnt == LAST_IDX) ? '0 : rdCnt + 1'b1;

    // Entry 0 is replayed on the edge that stores the final entry, so it must see that entry's ovf.
    assign firstRes = renorm(entP[0], entOvf[0], entFlags[0], shiftNext);
    assign nextRes  = renorm(entP[rdNext], entOvf[rdNext], entFlags[rdNext], shiftAcc);

    // NOTE: the buffer has no reset; every entry is rewritten before it is read, and a reset
    // only has to forget the block, which clearing wrCnt/rdCnt/state already does.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            entP[wrCnt]     <= in_p;
            entOvf[wrCnt]   <= in_ovf;
            entFlags[wrCnt] <= in_flags;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FILL;
            wrCnt       <= '0;
            rdCnt       <= '0;
            shiftAcc    <= '0;
            out_p       <= '0;
            out_flags   <= '0;
            out_last    <= 1'b0;
            block_shift <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (in_valid) begin
                        shiftAcc <= shiftNext;
                        wrCnt    <= wrCnt + 1'b1;
                        if (wrCnt == LAST_IDX) begin
                            state       <= DRAIN;
                            wrCnt       <= '0;
                            rdCnt       <= '0;
                            out_p       <= firstRes.p;
                            out_flags   <= firstRes.flags;
                            out_last    <= 1'b0;
                            block_shift <= shiftNext;
                        end
                    end
                end
                default: begin
                    if (out_ready) begin
                        if (rdCnt == LAST_IDX) begin
                            state     <= FILL;
                            rdCnt     <= '0;
                            shiftAcc  <= '0;
                            out_p     <= '0;
                            out_flags <= '0;
                            out_last  <= 1'b0;
                        end else begin
                            rdCnt     <= rdNext;
                            out_p     <= nextRes.p;
                            out_flags <= nextRes.flags;
                            out_last  <= (rdNext == LAST_IDX);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bmf_block_renorm.sv
// Scoreboard bench for bmf_block_renorm: each block's expected outputs are queued as it is
// driven, then popped and compared while the block drains.
module tb_bmf_block_renorm;

    localparam int BS = 8;
    localparam int INF = 2, ZERO = 3, SUB = 4, NORM = 5;
    localparam logic [5:0] F_INF  = 6'b000100;
    localparam logic [5:0] F_ZERO = 6'b001000;
    localparam logic [5:0] F_SUB  = 6'b010000;
    localparam logic [5:0] F_NORM = 6'b100000;

    typedef struct {
        logic [7:0] p;
        logic [5:0] flags;
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_p = '0;
    logic [4:0] in_ovf = '0;
    logic [5:0] in_flags = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_p;
    logic [5:0] out_flags;
    logic       out_last;
    logic [4:0] block_shift;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] blkP   [BS];
    logic [4:0] blkOvf [BS];
    logic [5:0] blkFl  [BS];
    logic [7:0] expP   [BS];
    logic [5:0] expFl  [BS];
    logic [4:0] expShift;
    exp_t       expQ[$];

    bmf_block_renorm #(.NEXP(4), .NSIG(3), .BLOCK_SIZE(BS), .LAST_FLAG(6)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_p(in_p), .in_ovf(in_ovf), .in_flags(in_flags),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_p(out_p), .out_flags(out_flags), .out_last(out_last),
        .block_shift(block_shift)
    );

    always #5 clk = ~clk;

    // Reference transform written with plain integers.
    function automatic void model_entry(input logic [7:0] p, input logic [5:0] fl, input int ovf,
                                        input int s, output logic [7:0] op, output logic [5:0] of);
        int e, m, n, k, v;
        logic [3:0] nf;
        logic [2:0] vf;
        e = fl[INF] ? 14 + ovf : (fl[SUB] ? 1 : int'(p[6:3]));
        m = (fl[SUB] ? 0 : 8) + int'(p[2:0]);
        n = e - s;
        k = 1 - n;
        v = (k > 3 || k < 0) ? 0 : (m >> k);
        if (fl[ZERO]) begin
            op = p; of = F_ZERO;
        end else if (n >= 1) begin
            nf = n[3:0]; op = {p[7], nf, p[2:0]}; of = F_NORM;
        end else if (v == 0) begin
            op = {p[7], 7'b0000001}; of = F_ZERO;
        end else begin
            vf = v[2:0]; op = {p[7], 4'b0000, vf}; of = F_SUB;
        end
    endfunction

    task automatic model_block();
        int s = 0;
        for (int i = 0; i < BS; i++)
            if (blkFl[i][INF] && int'(blkOvf[i]) > s) s = int'(blkOvf[i]);
        expShift = 5'(s);
        for (int i = 0; i < BS; i++)
            model_entry(blkP[i], blkFl[i], int'(blkOvf[i]), s, expP[i], expFl[i]);
    endtask

    task automatic push_expect();
        exp_t e;
        for (int i = 0; i < BS; i++) begin
            e.p = expP[i]; e.flags = expFl[i]; e.last = (i == BS - 1);
            expQ.push_back(e);
        end
    endtask

    task automatic fill_plain(input logic [7:0] p, input logic [5:0] fl, input logic [7:0] ep,
                              input logic [5:0] ef);
        for (int i = 0; i < BS; i++) begin
            blkP[i] = p; blkOvf[i] = '0; blkFl[i] = fl; expP[i] = ep; expFl[i] = ef;
        end
    endtask

    task automatic drive_block();
        push_expect();
        for (int i = 0; i < BS; i++) begin
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL fill_handshake entry %0d: in_ready=%b out_valid=%b, required 1/0",
                         i, in_ready, out_valid);
            end
            in_valid = 1'b1; in_p = blkP[i]; in_ovf = blkOvf[i]; in_flags = blkFl[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL first_latency: out_valid=%b in_ready=%b, required 1/0", out_valid, in_ready);
        end
    endtask

    task automatic drain_block(input int stallAt, input int stallLen, input int maxItems);
        int   idx = 0;
        int   stallLeft = stallLen;
        exp_t e;
        while (expQ.size() > 0 && idx < maxItems) begin
            e = expQ[0];
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_p !== e.p || out_flags !== e.flags ||
                out_last !== e.last || block_shift !== expShift) begin
                miscompares++;
                $display("FAIL drain_out idx %0d: valid=%b ready_in=%b p=%h flags=%b last=%b shift=%0d, required 1 0 p=%h flags=%b last=%b shift=%0d",
                         idx, out_valid, in_ready, out_p, out_flags, out_last, block_shift,
                         e.p, e.flags, e.last, expShift);
            end
            if (idx == stallAt && stallLeft > 0) begin
                out_ready = 1'b0;
                stallLeft--;
            end else begin
                out_ready = 1'b1;
                void'(expQ.pop_front());
                idx++;
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        if (idx == BS) begin
            vectors++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL back_to_fill: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_p !== 8'h00 || out_flags !== 6'b0 ||
            out_last !== 1'b0 || block_shift !== 5'd0) begin
            miscompares++;
            $display("FAIL %s: in_ready=%b out_valid=%b p=%h flags=%b last=%b shift=%0d, required 1 0 00 000000 0 0",
                     tag, in_ready, out_valid, out_p, out_flags, out_last, block_shift);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        check_reset_state("reset_state");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("after_release");
    endtask

    task automatic test_identity();
        fill_plain(8'h38, F_NORM, 8'h38, F_NORM);
        expShift = 5'd0;
        drive_block();
        drain_block(-1, 0, BS);
    endtask

    task automatic test_overflow();
        fill_plain(8'h38, F_NORM, 8'h28, F_NORM);
        blkP[0] = 8'h7A; blkFl[0] = F_INF; blkOvf[0] = 5'd2; expP[0] = 8'h72;
        expShift = 5'd2;
        drive_block();
        drain_block(-1, 0, BS);
    endtask

    task automatic test_subnormal();
        fill_plain(8'h38, F_NORM, 8'h28, F_NORM);
        blkP[5] = 8'h7A; blkFl[5] = F_INF; blkOvf[5] = 5'd2; expP[5] = 8'h72;
        blkP[1] = 8'h14; expP[1] = 8'h06; expFl[1] = F_SUB;
        blkP[2] = 8'h84; blkFl[2] = F_SUB; expP[2] = 8'h81; expFl[2] = F_SUB;
        expShift = 5'd2;
        drive_block();
        drain_block(-1, 0, BS);
    endtask

    task automatic test_zero();
        fill_plain(8'h38, F_NORM, 8'h08, F_NORM);
        blkP[0] = 8'h78; blkFl[0] = F_INF; blkOvf[0] = 5'd6; expP[0] = 8'h70;
        blkP[1] = 8'h08; expP[1] = 8'h01; expFl[1] = F_ZERO;
        blkP[2] = 8'h80; blkFl[2] = F_ZERO; expP[2] = 8'h80; expFl[2] = F_ZERO;
        blkP[3] = 8'h00; blkFl[3] = F_ZERO; blkOvf[3] = 5'd9; expP[3] = 8'h00; expFl[3] = F_ZERO;
        expShift = 5'd6;
        drive_block();
        drain_block(-1, 0, BS);
    endtask

    task automatic test_stall();
        logic [3:0] ex;
        logic [2:0] fr;
        for (int i = 0; i < BS; i++) begin
            ex = 4'(i + 1); fr = 3'(i);
            blkP[i] = {1'b0, ex, fr}; blkOvf[i] = '0; blkFl[i] = F_NORM;
            expP[i] = {1'b0, ex, fr}; expFl[i] = F_NORM;
        end
        expShift = 5'd0;
        drive_block();
        drain_block(3, 3, BS);
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < BS; i++) begin
            blkP[i] = {1'b1, 4'(i + 4), 3'(7 - i)}; blkOvf[i] = '0; blkFl[i] = F_NORM;
        end
        blkP[0] = 8'h78; blkFl[0] = F_INF; blkOvf[0] = 5'd3;
        model_block();
        drive_block();
        drain_block(-1, 0, 4);
        rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || block_shift !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_mid_drain: out_valid=%b shift=%0d, required 0 0", out_valid, block_shift);
        end
        expQ.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("release_mid_drain");
        test_identity();
    endtask

    task automatic test_back_to_back_random();
        int r;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < BS; i++) begin
                r = $urandom_range(0, 3);
                blkOvf[i] = 5'($urandom_range(0, 15));
                case (r)
                    0: begin blkFl[i] = F_NORM; blkP[i] = {1'($urandom), 4'($urandom_range(1, 14)), 3'($urandom)}; end
                    1: begin blkFl[i] = F_SUB;  blkP[i] = {1'($urandom), 4'b0000, 3'($urandom_range(1, 7))}; end
                    2: begin blkFl[i] = F_ZERO; blkP[i] = {1'($urandom), 7'b0000000}; end
                    default: begin blkFl[i] = F_INF; blkP[i] = {1'($urandom), 4'b1111, 3'($urandom)}; end
                endcase
            end
            model_block();
            drive_block();
            drain_block(b, b, BS);
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_overflow();
        test_subnormal();
        test_zero();
        test_stall();
        test_reset_mid_drain();
        test_back_to_back_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
